// File: rtl/benes_xbar_if.sv
// benes_xbar_if: configuration, input and output streams of the Benes crossbar
// Ports (slave = crossbar side):
//   cfg_valid/cfg_ready/cfg_ctrl : switch-bit word, accepted only while the pipeline is empty
//   in_valid/in_ready/in_data    : input lane vector
//   out_valid/out_ready/out_data : permuted lane vector
//   busy                         : at least one beat in flight
interface benes_xbar_if #(
    parameter int SIZE   = 32,
    parameter int DATA_W = 8
);
    localparam int TAGWIDTH = $clog2(SIZE);
    localparam int STAGES   = 2 * TAGWIDTH - 1;
    localparam int BITWIDTH = STAGES * SIZE / 2;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [BITWIDTH-1:0] cfg_ctrl;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data [SIZE];
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data [SIZE];
    logic                busy;
    modport master (
        output cfg_valid, cfg_ctrl, in_valid, in_data, out_ready,
        input  cfg_ready, in_ready, out_valid, out_data, busy
    );
    modport slave (
        input  cfg_valid, cfg_ctrl, in_valid, in_data, out_ready,
        output cfg_ready, in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/benes_xbar.sv
// benes_xbar: pipelined Benes permutation network, one registered stage per switch column
// Ports:
//   clk   : rising-edge clock
//   n_rst : synchronous active-low reset
//   io    : benes_xbar_if.slave (config, input and output handshakes, busy)
module benes_xbar #(
    parameter int SIZE   = 32,
    parameter int DATA_W = 8
) (
    input logic         clk,
    input logic         n_rst,
    benes_xbar_if.slave io
);
    localparam int TAGWIDTH = $clog2(SIZE);
    localparam int STAGES   = 2 * TAGWIDTH - 1;
    localparam int BITWIDTH = STAGES * SIZE / 2;
    localparam int HALF     = SIZE / 2;

    logic [STAGES-1:0]   valid_q, valid_d;
    logic                configured_q, configured_d;
    logic [BITWIDTH-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   data_q [STAGES][SIZE];
    logic [DATA_W-1:0]   data_d [STAGES][SIZE];
    logic [DATA_W-1:0]   src    [STAGES][SIZE];
    logic [DATA_W-1:0]   sw     [STAGES][SIZE];
    logic                advance, cfg_load, in_fire;
    int                  gap, pos;

    // Stall is global: the whole pipe moves only when the output slot is free
    assign advance      = !valid_q[STAGES-1] || io.out_ready;
    assign io.busy      = |valid_q;
    assign io.cfg_ready = ~|valid_q;
    assign io.out_valid = valid_q[STAGES-1];
    assign io.out_data  = data_q[STAGES-1];
    assign cfg_load     = io.cfg_valid && io.cfg_ready;
    assign io.in_ready  = n_rst && configured_q && !cfg_load && advance;
    assign in_fire      = io.in_valid && io.in_ready;

    // Butterfly gaps run 1,2,4..SIZE/2..4,2,1; each column switch j pairs lanes pos and pos+gap
    always_comb begin
        gap = 1;
        pos = 0;
        for (int s = 0; s < STAGES; s++) begin
            for (int i = 0; i < SIZE; i++) begin
                src[s][i] = (s == 0) ? io.in_data[i] : data_q[(s == 0) ? 0 : s - 1][i];
                sw[s][i]  = src[s][i];
            end
        end
        for (int s = 0; s < STAGES; s++) begin
            gap = 1 << ((s < STAGES - 1 - s) ? s : STAGES - 1 - s);
            for (int j = 0; j < HALF; j++) begin
                pos = (j % gap) + 2 * gap * (j / gap);
                sw[s][pos]       = ctrl_q[s * HALF + j] ? src[s][pos + gap] : src[s][pos];
                sw[s][pos + gap] = ctrl_q[s * HALF + j] ? src[s][pos] : src[s][pos + gap];
            end
        end
    end

    always_comb begin
        valid_d      = advance ? {valid_q[STAGES-2:0], in_fire} : valid_q;
        configured_d = configured_q || cfg_load;
        ctrl_d       = cfg_load ? io.cfg_ctrl : ctrl_q;
        for (int s = 0; s < STAGES; s++) begin
            for (int i = 0; i < SIZE; i++) begin
                data_d[s][i] = advance ? sw[s][i] : data_q[s][i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            valid_q      <= '0;
            configured_q <= 1'b0;
            ctrl_q       <= '0;
            data_q       <= '{default: '0};
        end else begin
            valid_q      <= valid_d;
            configured_q <= configured_d;
            ctrl_q       <= ctrl_d;
            data_q       <= data_d;
        end
    end
endmodule

// File: tb/tb_benes_xbar.sv
// tb_benes_xbar: scoreboard bench for benes_xbar with directed configs and vectors
module tb_benes_xbar;
    localparam int SIZE     = 32;
    localparam int DATA_W   = 8;
    localparam int STAGES   = 9;
    localparam int BITWIDTH = 144;
    typedef logic [SIZE*DATA_W-1:0] vec_t;
    typedef struct {
        vec_t d;
        int   stamp;
        bit   lat;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    benes_xbar_if #(.SIZE(SIZE), .DATA_W(DATA_W)) bus ();
    benes_xbar #(.SIZE(SIZE), .DATA_W(DATA_W)) dut (.clk(clk), .n_rst(n_rst), .io(bus));

    exp_t sbq[$];
    int   checks = 0, failures = 0, cyc = 0, got = 0, sent = 0, run = 0, last_run = 0;
    bit   lat_en = 1'b1, hold_v = 1'b0;
    vec_t held;
    int   perm [SIZE];
    logic [BITWIDTH-1:0] cfg_a, cfg_b, cfg_rev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t out_vec();
        vec_t v;
        for (int i = 0; i < SIZE; i++) v[i*DATA_W +: DATA_W] = bus.out_data[i];
        return v;
    endfunction

    function automatic vec_t seq_vec();
        vec_t v;
        for (int i = 0; i < SIZE; i++) v[i*DATA_W +: DATA_W] = DATA_W'(i);
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < SIZE; i++) v[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        return v;
    endfunction

    task automatic perm_identity();
        for (int i = 0; i < SIZE; i++) perm[i] = i;
    endtask

    task automatic perm_swap(input int a, input int b);
        int t;
        t = perm[a];
        perm[a] = perm[b];
        perm[b] = t;
    endtask

    // Monitor: pops the scoreboard on every output handshake, checks hold stability while stalled
    always @(negedge clk) begin
        vec_t cur;
        exp_t e;
        cur = out_vec();
        if (n_rst && bus.out_valid) begin
            run++;
            if (hold_v) check("stall_hold", cur, held);
            if (bus.out_ready) begin
                hold_v = 1'b0;
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_out: got beat %h expected none", cur);
                end else begin
                    e = sbq.pop_front();
                    got++;
                    check("out_data", cur, e.d);
                    if (e.lat) check("latency", vec_t'(cyc - e.stamp), vec_t'(STAGES));
                end
            end else begin
                hold_v = 1'b1;
                held = cur;
            end
        end else begin
            if (run != 0) last_run = run;
            run = 0;
            hold_v = 1'b0;
        end
    end

    task automatic send(input vec_t v);
        vec_t e;
        for (int i = 0; i < SIZE; i++) begin
            bus.in_data[i] = v[i*DATA_W +: DATA_W];
            e[i*DATA_W +: DATA_W] = v[perm[i]*DATA_W +: DATA_W];
        end
        bus.in_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sbq.push_back('{e, cyc, lat_en});
                sent++;
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        failures++;
        $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 40 cycles");
        bus.in_valid = 1'b0;
    endtask

    task automatic load_cfg(input logic [BITWIDTH-1:0] w);
        bus.cfg_ctrl = w;
        bus.cfg_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.cfg_ready) begin
                check("cfg_prio_in_ready", vec_t'(bus.in_ready), '0);
                @(posedge clk);
                #1;
                bus.cfg_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        failures++;
        $display("FAIL cfg_timeout: cfg_ready stayed 0, expected 1 within 40 cycles");
        bus.cfg_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !bus.busy) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sbq.size());
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected self termination");
        $fatal(1);
    end

    initial begin
        int lo;
        cfg_a = '0;
        cfg_a[0] = 1'b1;
        cfg_b = '0;
        cfg_b[0] = 1'b1;
        cfg_b[67] = 1'b1;
        cfg_b[101] = 1'b1;
        cfg_b[133] = 1'b1;
        cfg_rev = '0;
        cfg_rev[79:0] = '1;
        bus.cfg_valid = 1'b0;
        bus.cfg_ctrl = '0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < SIZE; i++) bus.in_data[i] = '0;
        bus.out_ready = 1'b1;
        perm_identity();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out_valid", vec_t'(bus.out_valid), '0);
        check("rst_busy", vec_t'(bus.busy), '0);
        check("rst_in_ready", vec_t'(bus.in_ready), '0);
        check("rst_cfg_ready", vec_t'(bus.cfg_ready), vec_t'(1));
        check("rst_out_data", out_vec(), '0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("precfg_in_ready", vec_t'(bus.in_ready), '0);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;

        load_cfg('0);
        send(seq_vec());
        drain();
        check("single_run", vec_t'(last_run), vec_t'(1));

        perm_swap(0, 1);
        load_cfg(cfg_a);
        send(seq_vec());
        send(rand_vec());
        drain();

        perm_swap(3, 19);
        perm_swap(9, 13);
        perm_swap(10, 11);
        load_cfg(cfg_b);
        send(seq_vec());
        send(rand_vec());
        drain();

        for (int i = 0; i < SIZE; i++) perm[i] = SIZE - 1 - i;
        load_cfg(cfg_rev);
        for (int k = 0; k < 32; k++) send(rand_vec());
        drain();
        check("burst_run", vec_t'(last_run), vec_t'(32));

        lat_en = 1'b0;
        fork
            begin
                for (int k = 0; k < 16; k++) send(rand_vec());
            end
            begin
                repeat (11) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", vec_t'(bus.in_ready), '0);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        lat_en = 1'b1;

        for (int k = 0; k < 3; k++) send(rand_vec());
        bus.cfg_ctrl = cfg_b;
        bus.cfg_valid = 1'b1;
        lo = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.cfg_ready) begin
                check("busy_cfg_in_ready", vec_t'(bus.in_ready), '0);
                break;
            end
            lo++;
        end
        check("cfg_wait_cycles", vec_t'(lo), vec_t'(9));
        @(posedge clk);
        #1;
        bus.cfg_valid = 1'b0;
        perm_identity();
        perm_swap(0, 1);
        perm_swap(3, 19);
        perm_swap(9, 13);
        perm_swap(10, 11);
        send(seq_vec());
        send(rand_vec());
        drain();

        for (int k = 0; k < 4; k++) send(rand_vec());
        n_rst = 1'b0;
        sent -= sbq.size();
        sbq.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_out_valid", vec_t'(bus.out_valid), '0);
        check("midrst_busy", vec_t'(bus.busy), '0);
        check("midrst_cfg_ready", vec_t'(bus.cfg_ready), vec_t'(1));
        check("midrst_in_ready", vec_t'(bus.in_ready), '0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        for (int i = 0; i < SIZE; i++) bus.in_data[i] = DATA_W'(i);
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_in_ready", vec_t'(bus.in_ready), '0);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        perm_identity();
        perm_swap(0, 1);
        load_cfg(cfg_a);
        send(seq_vec());
        drain();

        repeat (20) @(posedge clk);
        check("beats_out", vec_t'(got), vec_t'(sent));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
